// File: rtl/eeg_feat_pkg.sv
// Shared constants, FSM state encoding and saturating magnitude helper
// for the EEG mean-absolute-value feature stage.
package eeg_feat_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned MAG_W    = SAMPLE_W - 1;

  typedef enum logic [0:0] {
    RESYNC = 1'b0,
    ACCUM  = 1'b1
  } state_e;

  // |x| with -32768 clamped to 32767 so the magnitude always fits 15 bits
  function automatic logic [MAG_W-1:0] abs_sat16(input logic signed [SAMPLE_W-1:0] x);
    logic [MAG_W-1:0] m;
    if (x[SAMPLE_W-1]) begin
      if (x[SAMPLE_W-2:0] == '0) m = '1;
      else                       m = MAG_W'(-x);
    end else begin
      m = x[MAG_W-1:0];
    end
    return m;
  endfunction

endpackage

// File: rtl/eeg_feature_extractor_acc.sv
// Per-channel magnitude accumulator; a clear may be combined with an add
// so the first sample of a new window lands in the same cycle.
module eeg_mav_acc
  import eeg_feat_pkg::*;
#(
  parameter int unsigned ACC_W = MAG_W + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             add_en,
  input  logic [MAG_W-1:0] magnitude,
  output logic [ACC_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= add_en ? ACC_W'(magnitude) : '0;
    end else if (add_en) begin
      acc <= acc + ACC_W'(magnitude);
    end
  end

endmodule

// File: rtl/eeg_feature_extractor.sv
// Channel-interleaved EEG stream to per-channel MAV feature vector, with
// channel-order checking and drop-on-backpressure output register bank.
module eeg_feature_extractor
  import eeg_feat_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic [2:0]  s_chan,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic [15:0] f0,
  output logic [15:0] f1,
  output logic [15:0] f2,
  output logic [15:0] f3,
  output logic [15:0] f4,
  output logic [15:0] f5,
  output logic [15:0] f6,
  output logic [15:0] f7,
  output logic        seq_err,
  output logic        feat_overrun
);

  localparam int unsigned ACC_W    = MAG_W + LOG2_WIN;
  localparam logic [0:0]  S_RESYNC = RESYNC;
  localparam logic [0:0]  S_ACCUM  = ACCUM;

  logic [0:0]          state_q, state_d;
  logic [2:0]          chan_q, chan_d;
  logic [LOG2_WIN-1:0] row_q, row_d;
  logic                accept;
  logic [MAG_W-1:0]    mag;
  logic                clear;
  logic [NUM_CH-1:0]   add_en;
  logic                seq_err_d;
  logic                overrun_d;
  logic                load;
  logic [ACC_W-1:0]    acc [NUM_CH];
  logic [ACC_W-1:0]    last_sum;
  logic [SAMPLE_W-1:0] feat_new [NUM_CH];
  logic [SAMPLE_W-1:0] feat_q [NUM_CH];

  assign accept = s_valid && s_ready;
  assign mag    = abs_sat16(s_data);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_acc
    eeg_mav_acc #(.ACC_W(ACC_W)) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .add_en    (add_en[g]),
      .magnitude (mag),
      .acc       (acc[g])
    );
  end

  // Channel 7 is folded in combinationally since its last sample is not yet in acc
  always_comb begin
    last_sum = acc[NUM_CH-1] + ACC_W'(mag);
    for (int i = 0; i < NUM_CH; i++) begin
      feat_new[i] = SAMPLE_W'(acc[i] >> LOG2_WIN);
    end
    feat_new[NUM_CH-1] = SAMPLE_W'(last_sum >> LOG2_WIN);
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    row_d     = row_q;
    clear     = 1'b0;
    add_en    = '0;
    seq_err_d = 1'b0;
    overrun_d = 1'b0;
    load      = 1'b0;
    if (accept) begin
      case (state_q)
        S_RESYNC: begin
          if (s_chan == 3'd0) begin
            clear     = 1'b1;
            add_en[0] = 1'b1;
            chan_d    = 3'd1;
            row_d     = '0;
            state_d   = S_ACCUM;
          end
        end
        default: begin
          if (s_chan != chan_q) begin
            seq_err_d = 1'b1;
            clear     = 1'b1;
            row_d     = '0;
            if (s_chan == 3'd0) begin
              add_en[0] = 1'b1;
              chan_d    = 3'd1;
            end else begin
              chan_d  = 3'd0;
              state_d = S_RESYNC;
            end
          end else if ((chan_q == 3'd7) && (&row_q)) begin
            clear  = 1'b1;
            chan_d = 3'd0;
            row_d  = '0;
            if (!feat_valid || feat_ready) load = 1'b1;
            else                           overrun_d = 1'b1;
          end else begin
            add_en[chan_q] = 1'b1;
            chan_d         = chan_q + 3'd1;
            if (chan_q == 3'd7) row_d = row_q + LOG2_WIN'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RESYNC;
      chan_q       <= '0;
      row_q        <= '0;
      s_ready      <= 1'b0;
      feat_valid   <= 1'b0;
      seq_err      <= 1'b0;
      feat_overrun <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) feat_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      row_q        <= row_d;
      s_ready      <= 1'b1;
      seq_err      <= seq_err_d;
      feat_overrun <= overrun_d;
      if (load) begin
        feat_valid <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) feat_q[i] <= feat_new[i];
      end else if (feat_ready) begin
        feat_valid <= 1'b0;
      end
    end
  end

  assign f0 = feat_q[0];
  assign f1 = feat_q[1];
  assign f2 = feat_q[2];
  assign f3 = feat_q[3];
  assign f4 = feat_q[4];
  assign f5 = feat_q[5];
  assign f6 = feat_q[6];
  assign f7 = feat_q[7];

endmodule

// File: tb/tb_eeg_feature_extractor.sv
// Scoreboard bench: a window-level reference model pushes expected vectors
// and pulse expectations; a negedge monitor pops and compares.
module tb_eeg_feature_extractor;

  localparam int unsigned L   = 2;
  localparam int          WIN = 1 << L;
  localparam int          NS  = 8 * WIN;

  typedef logic [7:0][15:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [2:0]  s_chan = '0;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [15:0] f0, f1, f2, f3, f4, f5, f6, f7;
  logic        seq_err;
  logic        feat_overrun;

  eeg_feature_extractor #(.LOG2_WIN(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_chan       (s_chan),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .f0           (f0),
    .f1           (f1),
    .f2           (f2),
    .f3           (f3),
    .f4           (f4),
    .f5           (f5),
    .f6           (f6),
    .f7           (f7),
    .seq_err      (seq_err),
    .feat_overrun (feat_overrun)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  vec_t exp_q[$];
  int   win[$];
  bit   synced  = 0;
  bit   m_ready = 0;
  bit   m_held  = 0;
  bit   m_fzero = 1;
  bit   m_seq   = 0;
  bit   m_ovr   = 0;
  bit   mon_en  = 0;
  int   buf_w[NS];
  vec_t dv;

  assign dv = {f7, f6, f5, f4, f3, f2, f1, f0};

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int absx(input int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  // Reference: keeps the raw samples of the open window and averages at the end
  task automatic model_step();
    bit accepted;
    int x, c;
    int sum[8];
    vec_t v;
    m_seq  = 0;
    m_ovr  = 0;
    mon_en = 1;
    if (!rst_n) begin
      win.delete();
      exp_q.delete();
      synced  = 0;
      m_held  = 0;
      m_fzero = 1;
      m_ready = 0;
      return;
    end
    accepted = s_valid && m_ready;
    m_ready  = 1;
    if (m_held && feat_ready) m_held = 0;
    if (!accepted) return;
    x = int'($signed(s_data));
    c = int'(s_chan);
    if (!synced) begin
      if (c == 0) begin
        synced = 1;
        win.push_back(x);
      end
    end else if (c != win.size() % 8) begin
      m_seq = 1;
      win.delete();
      if (c == 0) win.push_back(x);
      else        synced = 0;
    end else begin
      win.push_back(x);
      if (win.size() == NS) begin
        for (int i = 0; i < 8; i++) sum[i] = 0;
        for (int i = 0; i < NS; i++) sum[i % 8] += absx(win[i]);
        for (int i = 0; i < 8; i++) v[i] = 16'(sum[i] / WIN);
        if (!m_held) begin
          exp_q.push_back(v);
          m_held  = 1;
          m_fzero = 0;
        end else begin
          m_ovr = 1;
        end
        win.delete();
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("s_ready", int'(s_ready), int'(m_ready));
      chk("feat_valid", int'(feat_valid), int'(m_held));
      chk("seq_err", int'(seq_err), int'(m_seq));
      chk("feat_overrun", int'(feat_overrun), int'(m_ovr));
      if (m_fzero) begin
        for (int i = 0; i < 8; i++) chk($sformatf("f%0d_reset", i), int'(dv[i]), 0);
      end
      if (feat_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_vector: got feat_valid=1 expected no vector at %0t", $time);
        end else begin
          for (int i = 0; i < 8; i++) chk($sformatf("f%0d", i), int'(dv[i]), int'(exp_q[0][i]));
          if (feat_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic smp(input int c, input int d);
    s_valid = 1'b1;
    s_chan  = 3'(c);
    s_data  = 16'(d);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b0;
      tick();
    end
  endtask

  task automatic send_buf(input bit ready_last);
    for (int i = 0; i < NS; i++) begin
      if (ready_last && i == NS - 1) feat_ready = 1'b1;
      smp(i % 8, buf_w[i]);
    end
  endtask

  task automatic fill_const(input int d);
    for (int i = 0; i < NS; i++) buf_w[i] = d;
  endtask

  initial begin
    int chn;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // constant input
    feat_ready = 1'b1;
    fill_const(100);
    send_buf(0);
    idle(3);

    // alternating sign on ch3, floor on ch5
    fill_const(0);
    for (int r = 0; r < WIN; r++) begin
      buf_w[r*8+3] = (r % 2 == 0) ? 200 : -200;
      buf_w[r*8+5] = (r == WIN - 1) ? 2 : 1;
    end
    send_buf(0);
    idle(3);

    // saturation
    fill_const(0);
    for (int r = 0; r < WIN; r++) begin
      buf_w[r*8+0] = -32768;
      buf_w[r*8+1] = 32767;
    end
    send_buf(0);
    idle(3);

    // sequence error then resync
    smp(0, 7); smp(1, 7); smp(3, 7);
    for (int c = 4; c < 8; c++) smp(c, 9);
    fill_const(50);
    send_buf(0);
    idle(3);

    // backpressure: hold, overrun, release, then completion with handshake
    feat_ready = 1'b0;
    for (int i = 0; i < NS; i++) buf_w[i] = int'($urandom_range(0, 2000)) - 1000;
    send_buf(0);
    fill_const(-321);
    send_buf(0);
    idle(3);
    feat_ready = 1'b1;
    idle(1);
    feat_ready = 1'b0;
    fill_const(77);
    send_buf(0);
    idle(2);
    fill_const(1234);
    send_buf(1);
    idle(3);

    // reset mid-window, then a sample on the release edge and a partial row
    fill_const(500);
    for (int i = 0; i < 10; i++) smp(i % 8, buf_w[i]);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    smp(0, 1000);
    for (int c = 1; c < 8; c++) smp(c, 1000);
    fill_const(60);
    send_buf(0);
    idle(3);

    // randomized stream with gaps, random backpressure and rare order faults
    chn = 0;
    for (int n = 0; n < 14 * NS; n++) begin
      feat_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        s_valid = 1'b0;
        s_chan  = 3'($urandom);
        s_data  = 16'($urandom);
        tick();
      end else begin
        int c, d;
        c = chn;
        if ($urandom_range(0, 199) == 0) c = int'($urandom_range(0, 7));
        d = int'($signed(16'($urandom)));
        if ($urandom_range(0, 15) == 0) d = -32768;
        smp(c, d);
        chn = (chn + 1) % 8;
      end
    end

    feat_ready = 1'b1;
    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
